// File: rtl/repairmb_partner_responder.sv
// Responder side of MBINIT.REPAIRMB. It answers the initiator's start, apply_degrade
// and end sideband requests, latches the lane map announced by the partner, and
// asks for a repeater retrain whenever the partner reports that no lanes survive.
module repairmb_partner_responder #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd8_000_000,
    parameter int          MAX_RETRY      = 3
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       i_MBINIT_REVERSALMB_end,
    input  logic [3:0] i_RX_SbMessage,
    input  logic       i_msg_valid,
    input  logic [2:0] i_msg_info,
    input  logic       i_Busy_SideBand,
    input  logic       i_falling_edge_busy,
    output logic [3:0] o_TX_SbMessage,
    output logic       o_ValidOutDatat_partner,
    output logic [1:0] o_Functional_Lanes_partner,
    output logic       o_Start_Repeater,
    output logic       o_MBINIT_REPAIRMB_partner_end,
    output logic       o_error
);

    localparam logic [3:0] MSG_START_REQ    = 4'b0001;
    localparam logic [3:0] MSG_START_RESP   = 4'b0010;
    localparam logic [3:0] MSG_END_REQ      = 4'b0011;
    localparam logic [3:0] MSG_END_RESP     = 4'b0100;
    localparam logic [3:0] MSG_DEGRADE_REQ  = 4'b0101;
    localparam logic [3:0] MSG_DEGRADE_RESP = 4'b0110;
    localparam logic [7:0] RETRY_MAX        = 8'(MAX_RETRY);

    typedef enum logic [3:0] {
        ST_IDLE, ST_WAIT_START, ST_BUSY_S, ST_SEND_S, ST_WAIT_REQ,
        ST_BUSY_D, ST_SEND_D, ST_BUSY_E, ST_SEND_E, ST_DONE, ST_ERROR
    } state_t;

    state_t      state, nxt;
    logic [23:0] timer;
    logic [7:0]  retry;
    logic        latch_lanes, rep_pulse, retry_inc, counting, timeout, tx_done;

    // Response code carried while the FSM sits in a SEND state.
    function automatic logic [3:0] send_code(input state_t s);
        case (s)
            ST_SEND_S: send_code = MSG_START_RESP;
            ST_SEND_D: send_code = MSG_DEGRADE_RESP;
            ST_SEND_E: send_code = MSG_END_RESP;
            default:   send_code = 4'b0000;
        endcase
    endfunction

    // Next-state decode; abort (enable low) overrides every other event.
    always_comb begin
        nxt         = state;
        latch_lanes = 1'b0;
        rep_pulse   = 1'b0;
        retry_inc   = 1'b0;
        counting    = (state == ST_WAIT_START) || (state == ST_WAIT_REQ) ||
                      (state == ST_BUSY_S) || (state == ST_BUSY_D) || (state == ST_BUSY_E);
        timeout     = (timer >= (TIMEOUT_CYCLES - 24'd1));
        // A falling-edge pulse only counts as completion if busy is really low.
        tx_done     = i_falling_edge_busy && !i_Busy_SideBand;
        if (!i_MBINIT_REVERSALMB_end) begin
            nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:       nxt = ST_WAIT_START;
                ST_WAIT_START: begin
                    if (i_msg_valid && i_RX_SbMessage == MSG_START_REQ) nxt = ST_BUSY_S;
                    else if (timeout)                                   nxt = ST_ERROR;
                end
                ST_BUSY_S: begin
                    if (!i_Busy_SideBand) nxt = ST_SEND_S;
                    else if (timeout)     nxt = ST_ERROR;
                end
                ST_BUSY_D: begin
                    if (!i_Busy_SideBand) nxt = ST_SEND_D;
                    else if (timeout)     nxt = ST_ERROR;
                end
                ST_BUSY_E: begin
                    if (!i_Busy_SideBand) nxt = ST_SEND_E;
                    else if (timeout)     nxt = ST_ERROR;
                end
                ST_SEND_S: if (tx_done) nxt = ST_WAIT_REQ;
                ST_SEND_D: if (tx_done) nxt = ST_WAIT_REQ;
                ST_SEND_E: if (tx_done) nxt = ST_DONE;
                ST_WAIT_REQ: begin
                    if (i_msg_valid && i_RX_SbMessage == MSG_DEGRADE_REQ) begin
                        latch_lanes = 1'b1;
                        if (i_msg_info[1:0] == 2'b00) begin
                            // No surviving lanes: retrain through the repeater, bounded.
                            if (retry == RETRY_MAX) begin
                                nxt = ST_ERROR;
                            end else begin
                                retry_inc = 1'b1;
                                rep_pulse = 1'b1;
                                nxt       = ST_BUSY_D;
                            end
                        end else begin
                            nxt = ST_BUSY_D;
                        end
                    end else if (i_msg_valid && i_RX_SbMessage == MSG_END_REQ) begin
                        nxt = ST_BUSY_E;
                    end else if (i_msg_valid && i_RX_SbMessage == MSG_START_REQ) begin
                        nxt = ST_BUSY_S;
                    end else if (timeout) begin
                        nxt = ST_ERROR;
                    end
                end
                ST_DONE:  nxt = ST_DONE;
                ST_ERROR: nxt = ST_ERROR;
                default:  nxt = ST_IDLE;
            endcase
        end
    end

    // State, wait timer, retry count and lane latch.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state                      <= ST_IDLE;
            timer                      <= 24'd0;
            retry                      <= 8'd0;
            o_Functional_Lanes_partner <= 2'b11;
        end else begin
            state <= nxt;
            if (nxt != state)  timer <= 24'd0;
            else if (counting) timer <= timer + 24'd1;
            if (nxt == ST_IDLE) retry <= 8'd0;
            else if (retry_inc) retry <= retry + 8'd1;
            if (state != ST_IDLE && nxt == ST_IDLE) o_Functional_Lanes_partner <= 2'b11;
            else if (latch_lanes)                   o_Functional_Lanes_partner <= i_msg_info[1:0];
        end
    end

    // Registered outputs decoded from the next state.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            o_TX_SbMessage                <= 4'b0000;
            o_ValidOutDatat_partner       <= 1'b0;
            o_Start_Repeater              <= 1'b0;
            o_MBINIT_REPAIRMB_partner_end <= 1'b0;
            o_error                       <= 1'b0;
        end else begin
            o_TX_SbMessage                <= send_code(nxt);
            o_ValidOutDatat_partner       <= (nxt != state) && (send_code(nxt) != 4'b0000);
            o_Start_Repeater              <= rep_pulse;
            o_MBINIT_REPAIRMB_partner_end <= (nxt == ST_DONE);
            o_error                       <= (nxt == ST_ERROR);
        end
    end

endmodule

// File: tb/tb_repairmb_partner_responder.sv
// Bench for repairmb_partner_responder: directed scenarios followed by random traffic,
// all checked every cycle against a session-level model of the responder.
module tb_repairmb_partner_responder;

    localparam int TO = 100;
    localparam int MR = 3;
    localparam int P_IDLE = 0, P_AWAIT_START = 1, P_AWAIT_REQ = 2, P_DONE = 3, P_ERR = 4;

    logic       clk = 1'b0;
    logic       rst_n, en, mv, busy, feb;
    logic [3:0] msg;
    logic [2:0] info;
    logic [3:0] o_tx;
    logic       o_valid, o_rep, o_end, o_err;
    logic [1:0] o_lanes;

    int errs = 0;
    int checks = 0;

    // Model: session phase, response waiting for the bus, response on the bus.
    int phase, aftr, pend, hold, lanes, retry, timer;
    int m_tx, m_valid, m_rep, m_end, m_err;

    repairmb_partner_responder #(.TIMEOUT_CYCLES(24'(TO)), .MAX_RETRY(MR)) dut (
        .CLK(clk), .rst_n(rst_n), .i_MBINIT_REVERSALMB_end(en),
        .i_RX_SbMessage(msg), .i_msg_valid(mv), .i_msg_info(info),
        .i_Busy_SideBand(busy), .i_falling_edge_busy(feb),
        .o_TX_SbMessage(o_tx), .o_ValidOutDatat_partner(o_valid),
        .o_Functional_Lanes_partner(o_lanes), .o_Start_Repeater(o_rep),
        .o_MBINIT_REPAIRMB_partner_end(o_end), .o_error(o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit chg, waiting;
        m_valid = 0; m_rep = 0; chg = 0;
        if (!rst_n) begin
            phase = P_IDLE; aftr = P_IDLE; pend = 0; hold = 0;
            lanes = 3; retry = 0; timer = 0;
        end else if (!en) begin
            if (phase != P_IDLE || pend != 0 || hold != 0) lanes = 3;
            phase = P_IDLE; pend = 0; hold = 0; retry = 0; timer = 0;
        end else begin
            waiting = (hold == 0) && (pend != 0 || phase == P_AWAIT_START || phase == P_AWAIT_REQ);
            if (hold != 0) begin
                if (feb && !busy) begin hold = 0; phase = aftr; chg = 1; end
            end else if (pend != 0) begin
                if (!busy) begin hold = pend; pend = 0; m_valid = 1; chg = 1; end
            end else begin
                case (phase)
                    P_IDLE: begin phase = P_AWAIT_START; chg = 1; end
                    P_AWAIT_START:
                        if (mv && msg == 4'd1) begin pend = 2; aftr = P_AWAIT_REQ; chg = 1; end
                    P_AWAIT_REQ: begin
                        if (mv && msg == 4'd5) begin
                            lanes = int'(info[1:0]); chg = 1;
                            if (info[1:0] == 2'b00 && retry == MR) phase = P_ERR;
                            else begin
                                if (info[1:0] == 2'b00) begin retry++; m_rep = 1; end
                                pend = 6; aftr = P_AWAIT_REQ;
                            end
                        end else if (mv && msg == 4'd3) begin
                            pend = 4; aftr = P_DONE; chg = 1;
                        end else if (mv && msg == 4'd1) begin
                            pend = 2; aftr = P_AWAIT_REQ; chg = 1;
                        end
                    end
                    default: ;
                endcase
            end
            if (chg) timer = 0;
            else if (waiting) begin
                if (timer == TO - 1) begin phase = P_ERR; pend = 0; timer = 0; end
                else timer++;
            end
        end
        m_tx  = hold;
        m_end = (phase == P_DONE);
        m_err = (phase == P_ERR);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(posedge clk) begin
        model_step();
        #1;
        chk("tx_msg", int'(o_tx), m_tx);
        chk("valid", int'(o_valid), m_valid);
        chk("lanes", int'(o_lanes), lanes);
        chk("repeater", int'(o_rep), m_rep);
        chk("end", int'(o_end), m_end);
        chk("error", int'(o_err), m_err);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic req(input logic [3:0] code, input logic [2:0] inf);
        mv = 1'b1; msg = code; info = inf;
        @(negedge clk);
        mv = 1'b0; msg = 4'd0; info = 3'd0;
    endtask

    task automatic complete();
        busy = 1'b0; feb = 1'b1;
        @(negedge clk);
        feb = 1'b0;
    endtask

    task automatic restart();
        en = 1'b0; tick(1);
        en = 1'b1; tick(1);
        req(4'd1, 3'd0); tick(1); complete();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mv = 1'b0; busy = 1'b0; feb = 1'b0;
        msg = 4'd0; info = 3'd0;
        tick(2);
        chk("rst_tx", int'(o_tx), 0);
        chk("rst_lanes", int'(o_lanes), 3);
        chk("rst_err", int'(o_err), 0);
        rst_n = 1'b1; en = 1'b1; tick(1);

        // Happy path with busy low.
        req(4'd1, 3'd0); tick(1);
        chk("start_strobe", int'(o_valid), 1);
        chk("start_code", int'(o_tx), 2);
        tick(1);
        chk("start_strobe_once", int'(o_valid), 0);
        chk("start_code_hold", int'(o_tx), 2);
        complete();
        req(4'd5, 3'b011); tick(1);
        chk("deg_code", int'(o_tx), 6);
        chk("deg_lanes11", int'(o_lanes), 3);
        complete();
        req(4'd3, 3'd0); tick(1);
        chk("end_code", int'(o_tx), 4);
        complete();
        chk("done_level", int'(o_end), 1);

        // Degrade with retry.
        restart();
        for (int i = 0; i < 2; i++) begin
            req(4'd5, 3'b000);
            chk("retry_pulse", int'(o_rep), 1);
            tick(1);
            chk("retry_resp", int'(o_tx), 6);
            complete();
        end
        req(4'd5, 3'b001);
        chk("no_pulse", int'(o_rep), 0);
        tick(1);
        chk("lanes01", int'(o_lanes), 1);
        complete();

        // Retry exhaustion.
        restart();
        for (int i = 0; i < MR; i++) begin
            req(4'd5, 3'b000); tick(1); complete();
        end
        req(4'd5, 3'b000);
        chk("exhaust_err", int'(o_err), 1);
        tick(2);
        chk("exhaust_no_resp", int'(o_tx), 0);

        // Reset while a degrade response is on the bus.
        restart();
        req(4'd5, 3'b010); tick(1);
        chk("pre_rst_code", int'(o_tx), 6);
        rst_n = 1'b0; tick(2);
        chk("mid_rst_tx", int'(o_tx), 0);
        chk("mid_rst_lanes", int'(o_lanes), 3);
        rst_n = 1'b1; tick(1);

        // Busy holding off the response, then timeout.
        busy = 1'b1;
        req(4'd1, 3'd0); tick(5);
        chk("busy_hold", int'(o_valid), 0);
        busy = 1'b0; tick(1);
        chk("busy_release", int'(o_valid), 1);
        complete();
        tick(TO - 1);
        chk("pre_timeout", int'(o_err), 0);
        tick(1);
        chk("timeout", int'(o_err), 1);

        // Abort during the end response, then a full handshake again.
        restart();
        req(4'd5, 3'b010); tick(1); complete();
        req(4'd3, 3'd0); tick(1);
        chk("abort_pre_lanes", int'(o_lanes), 2);
        en = 1'b0; tick(1);
        chk("abort_end", int'(o_end), 0);
        chk("abort_lanes", int'(o_lanes), 3);
        chk("abort_tx", int'(o_tx), 0);
        en = 1'b1; tick(1);
        req(4'd1, 3'd0); tick(1); complete();
        req(4'd5, 3'b011); tick(1); complete();
        req(4'd3, 3'd0); tick(1); complete();
        chk("rehandshake_end", int'(o_end), 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            en    = ($urandom_range(0, 99) != 0);
            mv    = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: msg = 4'd1;
                1: msg = 4'd3;
                2: msg = 4'd5;
                default: msg = 4'($urandom);
            endcase
            info = 3'($urandom);
            busy = ($urandom_range(0, 2) == 0);
            feb  = ($urandom_range(0, 3) == 0);
            tick(1);
        end
        rst_n = 1'b1; en = 1'b0; mv = 1'b0; feb = 1'b0;
        tick(2);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
